mat_loader: RTL

- Upstream feeder for the 64x64 matrix-multiply controller.
- Accepts a byte stream over a valid/ready handshake and writes 4096 elements of matrix A into SRAM_A, then 4096 elements of B into SRAM_B, row-major.
- After both matrices are loaded, issues a one-cycle start pulse to the multiply controller and waits for its done pulse. It then returns to idle, ready for the next matrix pair.

---
 rtl/mat_loader_pkg.sv | 13 +
 rtl/mat_loader_elem_counter.sv | 21 ++
 rtl/mat_loader.sv | 90 +++++++++
 3 files changed

// File: rtl/mat_loader_pkg.sv
// mat_loader_pkg: shared state encoding and sizing constants for the matrix loader
package mat_loader_pkg;
  localparam int MAT_DIM = 64;
  localparam int ADDR_W = $clog2(MAT_DIM * MAT_DIM);
  localparam int DATA_W = 8;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_A    = 3'd1,
    LOAD_B    = 3'd2,
    START     = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;
endpackage

// File: rtl/mat_loader_elem_counter.sv
// elem_counter: element address counter with enable, sync clear and terminal-count flag
module elem_counter
  import mat_loader_pkg::*;
#(
  parameter int CNT_W = ADDR_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : inc ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
  assign tc  = &cnt_q;
endmodule

// File: rtl/mat_loader.sv
// mat_loader: streams matrix A then B into their SRAMs, then kicks the multiply and awaits done
module mat_loader #(
  parameter int ADDR_W = mat_loader_pkg::ADDR_W,
  parameter int DATA_W = mat_loader_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load_en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_data,
  output logic              nce_a,
  output logic              nwrt_a,
  output logic              nce_b,
  output logic              nwrt_b,
  output logic              start,
  input  logic              mac_done,
  output logic              busy,
  output logic [7:0]        run_cnt
);
  import mat_loader_pkg::*;
  state_t state_q, state_d;
  logic in_ready_q, in_ready_d, busy_q, busy_d, start_q, start_d;
  logic ns_a_q, ns_a_d, ns_b_q, ns_b_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d, elem_cnt;
  logic [DATA_W-1:0] sram_data_q, sram_data_d;
  logic [7:0] run_cnt_q, run_cnt_d;
  logic fire, tc;
  elem_counter #(.CNT_W(ADDR_W)) u_cnt (
    .clk, .rstn, .inc(fire), .clr(state_q == IDLE), .cnt(elem_cnt), .tc
  );
  // a done pulse coinciding with start cannot be a real completion
  always_comb begin
    fire = in_valid && in_ready_q;
    state_d = state_q;
    run_cnt_d = run_cnt_q;
    case (state_q)
      IDLE:      state_d = load_en ? LOAD_A : IDLE;
      LOAD_A:    state_d = (fire && tc) ? LOAD_B : LOAD_A;
      LOAD_B:    state_d = (fire && tc) ? START : LOAD_B;
      START:     state_d = WAIT_DONE;
      WAIT_DONE: if (mac_done && !start_q) begin
        state_d = IDLE;
        run_cnt_d = run_cnt_q + 8'd1;
      end
      default:   state_d = IDLE;
    endcase
    in_ready_d = state_d == LOAD_A || state_d == LOAD_B;
    busy_d = state_d != IDLE;
    start_d = state_q == START;
    ns_a_d = !(fire && state_q == LOAD_A);
    ns_b_d = !(fire && state_q == LOAD_B);
    sram_addr_d = fire ? elem_cnt : sram_addr_q;
    sram_data_d = fire ? in_data : sram_data_q;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      in_ready_q <= 1'b0;
      busy_q <= 1'b0;
      start_q <= 1'b0;
      ns_a_q <= 1'b1;
      ns_b_q <= 1'b1;
      sram_addr_q <= '0;
      sram_data_q <= '0;
      run_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      in_ready_q <= in_ready_d;
      busy_q <= busy_d;
      start_q <= start_d;
      ns_a_q <= ns_a_d;
      ns_b_q <= ns_b_d;
      sram_addr_q <= sram_addr_d;
      sram_data_q <= sram_data_d;
      run_cnt_q <= run_cnt_d;
    end
  assign in_ready = in_ready_q;
  assign busy = busy_q;
  assign start = start_q;
  assign nce_a = ns_a_q;
  assign nwrt_a = ns_a_q;
  assign nce_b = ns_b_q;
  assign nwrt_b = ns_b_q;
  assign sram_addr = sram_addr_q;
  assign sram_data = sram_data_q;
  assign run_cnt = run_cnt_q;
endmodule
